// File: rtl/cnn_pool_pkg.sv
// cnn_pool_pkg: shared constants, state type and per-lane signed max for the 2x2 max-pool stage
package cnn_pool_pkg;
   localparam int LANES    = 13;
   localparam int DATA_W   = 16;
   localparam int MAX_W    = 416;
   localparam int DIM_W    = 10;
   localparam int PIX_W    = LANES * DATA_W;
   localparam int LB_DEPTH = MAX_W / 2;
   localparam int LB_AW    = $clog2(LB_DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   function automatic logic [PIX_W-1:0] lane_max(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
      lane_max = a;
      for (int k = 0; k < LANES; k++)
         if ($signed(b[k*DATA_W +: DATA_W]) > $signed(a[k*DATA_W +: DATA_W]))
            lane_max[k*DATA_W +: DATA_W] = b[k*DATA_W +: DATA_W];
   endfunction
endpackage

// File: rtl/cnn_pool_line_buf.sv
// cnn_pool_line_buf: half-row line buffer, simple dual-port, sync write / sync read, contents not reset
module cnn_pool_line_buf
   import cnn_pool_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [LB_AW-1:0] waddr,
   input  logic [PIX_W-1:0] wdata,
   input  logic             re,
   input  logic [LB_AW-1:0] raddr,
   output logic [PIX_W-1:0] rdata
);
   logic [PIX_W-1:0] mem [LB_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/cnn_maxpool_2x2.sv
// cnn_maxpool_2x2: 2x2 stride-2 max-pool over raster-order pixels of LANES signed lanes.
// Optional CNN_MAXPOOL_BYPASS_EN adds pool_en; when sampled low, beats pass straight through.
module cnn_maxpool_2x2
   import cnn_pool_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pool_start,
   input  logic [DIM_W-1:0] img_width,
   input  logic [DIM_W-1:0] img_height,
`ifdef CNN_MAXPOOL_BYPASS_EN
   input  logic             pool_en,
`endif
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_data,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_data,
   output logic             busy,
   output logic             frame_done,
   output logic             cfg_err
);
   state_t state;
   logic [DIM_W-1:0] w_r, h_r, col, row;
   logic [PIX_W-1:0] hold_reg, hmax, rd_data;
   logic beat, last_col, last_row, pool_on, cfg_ok;

`ifdef CNN_MAXPOOL_BYPASS_EN
   logic pool_en_r;
   assign pool_on = pool_en_r;
`else
   assign pool_on = 1'b1;
`endif

   assign cfg_ok   = img_width >= DIM_W'(2) && img_width <= DIM_W'(MAX_W) && img_height >= DIM_W'(2);
   // a restart in the same cycle as a beat takes priority and drops the beat
   assign beat     = state == RUN && in_valid && !pool_start;
   assign last_col = col == w_r - DIM_W'(1);
   assign last_row = row == h_r - DIM_W'(1);
   assign hmax     = lane_max(hold_reg, in_data);
   assign busy     = state == RUN;

   cnn_pool_line_buf u_line_buf (
      .clk   (clk),
      .we    (beat && pool_on && !row[0] && col[0]),
      .waddr (col[LB_AW:1]),
      .wdata (hmax),
      .re    (beat && pool_on && row[0] && !col[0]),
      .raddr (col[LB_AW:1]),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         w_r        <= '0;
         h_r        <= '0;
         col        <= '0;
         row        <= '0;
         hold_reg   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
         cfg_err    <= 1'b0;
`ifdef CNN_MAXPOOL_BYPASS_EN
         pool_en_r  <= 1'b1;
`endif
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (pool_start) begin
            cfg_err <= !cfg_ok;
            state   <= cfg_ok ? RUN : IDLE;
            w_r     <= img_width;
            h_r     <= img_height;
            col     <= '0;
            row     <= '0;
`ifdef CNN_MAXPOOL_BYPASS_EN
            pool_en_r <= pool_en;
`endif
         end else if (beat) begin
            if (!col[0]) hold_reg <= in_data;
            if (!pool_on) begin
               out_data  <= in_data;
               out_valid <= 1'b1;
            end else if (row[0] && col[0]) begin
               out_data  <= lane_max(rd_data, hmax);
               out_valid <= 1'b1;
            end
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) begin
               row <= row + 1'b1;
               if (last_row) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_cnn_maxpool_2x2.sv
// tb_cnn_maxpool_2x2: directed table of single-window frames plus hand sequences for
// multi-window frames, odd dims, gapped input, config errors, restart and mid-frame reset.
module tb_cnn_maxpool_2x2;
   localparam int LANES = 13;
   localparam int DW    = 16;
   localparam int PW    = LANES * DW;

   logic clk = 1'b0, rst_n = 1'b0, pool_start = 1'b0, in_valid = 1'b0;
   logic [9:0] img_width = '0, img_height = '0;
   logic [PW-1:0] in_data = '0;
   logic out_valid, busy, frame_done, cfg_err;
   logic [PW-1:0] out_data;
`ifdef CNN_MAXPOOL_BYPASS_EN
   logic pool_en = 1'b1;
`endif

   int errors = 0, checks = 0, cyc = 0, e;
   logic [PW-1:0] outq[$], ref_q[$];
   int outc[$], donec[$], be[$];

   typedef struct packed {
      logic [0:3][DW-1:0] ev;
      logic [0:3][DW-1:0] od;
      logic [DW-1:0]      xe;
      logic [DW-1:0]      xo;
   } vec_t;
   vec_t tbl[6];

   cnn_maxpool_2x2 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pool_start (pool_start),
      .img_width  (img_width),
      .img_height (img_height),
`ifdef CNN_MAXPOOL_BYPASS_EN
      .pool_en    (pool_en),
`endif
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .busy       (busy),
      .frame_done (frame_done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_valid) begin outq.push_back(out_data); outc.push_back(cyc); end
      if (frame_done) donec.push_back(cyc);
   end

   task automatic chk(input string n, input logic [PW-1:0] a, input logic [PW-1:0] x);
      checks++;
      if (a !== x) begin errors++; $display("FAIL %s: got %h expected %h", n, a, x); end
   endtask

   task automatic chki(input string n, input int a, input int x);
      checks++;
      if (a !== x) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, x); end
   endtask

   function automatic logic [PW-1:0] fill(input logic [DW-1:0] ev, input logic [DW-1:0] od);
      for (int k = 0; k < LANES; k++) fill[k*DW +: DW] = (k % 2 == 1) ? od : ev;
   endfunction

   function automatic logic [PW-1:0] pix(input int t, input int r, input int c);
      int v;
      for (int k = 0; k < LANES; k++) begin
         case (t)
            0: v = k * r * c;
            1: v = (k != 0) ? 0 : (r == 1 && c == 3) ? -32768 : -1;
            2: v = (r * 4 + c) * (k + 1) * 37 - 700;
            3: v = 1000 - (r * 4 + c) * (k + 3) * 11;
            default: v = 30000;
         endcase
         pix[k*DW +: DW] = DW'(v);
      end
   endfunction

   function automatic logic [PW-1:0] win(input int t, input int r, input int c);
      logic [PW-1:0] p[4];
      p[0] = pix(t, 2*r, 2*c);   p[1] = pix(t, 2*r, 2*c+1);
      p[2] = pix(t, 2*r+1, 2*c); p[3] = pix(t, 2*r+1, 2*c+1);
      win = p[0];
      for (int k = 0; k < LANES; k++)
         for (int i = 1; i < 4; i++)
            if ($signed(p[i][k*DW +: DW]) > $signed(win[k*DW +: DW])) win[k*DW +: DW] = p[i][k*DW +: DW];
   endfunction

   task automatic start(input int w, input int h, input logic v = 1'b0, input logic [PW-1:0] d = '0);
      @(negedge clk); pool_start = 1'b1; img_width = 10'(w); img_height = 10'(h); in_valid = v; in_data = d;
      @(negedge clk); pool_start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic send(input logic [PW-1:0] d, output int edge_no);
      @(negedge clk); in_valid = 1'b1; in_data = d; edge_no = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); in_valid = 1'b0; end
   endtask

   task automatic frame(input int t, input int w, input int h, input bit gap);
      int x;
      be.delete();
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            send(pix(t, r, c), x); be.push_back(x);
            if (gap) idle($urandom_range(1, 7));
         end
      idle(3);
   endtask

   task automatic clrq();
      outq.delete(); outc.delete(); donec.delete();
   endtask

   initial begin
      tbl[0] = '{ev:{16'd1, 16'd2, 16'd3, 16'd4},           od:{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC}, xe:16'd4,     xo:16'hFFFF};
      tbl[1] = '{ev:{16'd5, 16'hFFFB, 16'd0, 16'd0},        od:{16'd0, 16'd0, 16'd0, 16'd0},             xe:16'd5,     xo:16'd0};
      tbl[2] = '{ev:{16'h8000, 16'h7FFF, 16'hFFFF, 16'd0},  od:{16'h8000, 16'h8000, 16'h8000, 16'h8000}, xe:16'h7FFF,  xo:16'h8000};
      tbl[3] = '{ev:{16'd7, 16'd7, 16'd7, 16'd7},           od:{16'd100, 16'hFF9C, 16'd200, 16'hFF38},   xe:16'd7,     xo:16'd200};
      tbl[4] = '{ev:{16'hFFFF, 16'h8000, 16'hFFFE, 16'hFFFD}, od:{16'h7FFF, 16'h7FFE, 16'h7FFD, 16'h8000}, xe:16'hFFFF, xo:16'h7FFF};
      tbl[5] = '{ev:{16'd0, 16'hFFFF, 16'd1, 16'hFFFE},     od:{16'hFED4, 16'hFF38, 16'hFF9C, 16'hFE70}, xe:16'd1,     xo:16'hFF9C};

      repeat (2) @(negedge clk);
      chki("reset out_valid", int'(out_valid), 0);
      chk("reset out_data", out_data, '0);
      chki("reset busy", int'(busy), 0);
      chki("reset frame_done", int'(frame_done), 0);
      chki("reset cfg_err", int'(cfg_err), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         clrq(); start(2, 2);
         for (int j = 0; j < 4; j++) send(fill(tbl[i].ev[j], tbl[i].od[j]), e);
         idle(3);
         chki($sformatf("tbl%0d count", i), outq.size(), 1);
         if (outq.size() > 0) begin
            chk($sformatf("tbl%0d data", i), outq[0], fill(tbl[i].xe, tbl[i].xo));
            chki($sformatf("tbl%0d latency", i), outc[0], e);
         end
         chki($sformatf("tbl%0d done", i), donec.size() > 0 ? donec[0] : -1, e);
      end

      clrq(); start(4, 4);
      chki("w4h4 busy", int'(busy), 1);
      frame(0, 4, 4, 1'b0);
      chki("w4h4 count", outq.size(), 4);
      for (int i = 0; i < 4 && i < outq.size(); i++) begin
         chk($sformatf("w4h4 win%0d", i), outq[i], win(0, i / 2, i % 2));
         chki($sformatf("w4h4 lat%0d", i), outc[i], be[(i / 2) * 8 + (i % 2) * 2 + 5]);
      end
      if (outq.size() == 4) chki("w4h4 lane5", int'(outq[3][5*DW +: DW]), 45);
      chki("w4h4 done", donec.size() > 0 ? donec[0] : -1, be[15]);
      chki("w4h4 idle", int'(busy), 0);

      clrq(); start(5, 3);
      frame(1, 5, 3, 1'b0);
      chki("w5h3 count", outq.size(), 2);
      for (int i = 0; i < 2 && i < outq.size(); i++) chk($sformatf("w5h3 win%0d", i), outq[i], pix(1, 0, 0));
      chki("w5h3 done", donec.size() > 0 ? donec[0] : -1, be[14]);

      clrq(); start(4, 2);
      frame(2, 4, 2, 1'b0);
      ref_q = outq;
      clrq(); start(4, 2);
      frame(2, 4, 2, 1'b1);
      chki("gap count", outq.size(), 2);
      for (int i = 0; i < 2 && i < outq.size(); i++) begin
         chk($sformatf("gap win%0d", i), outq[i], win(2, 0, i));
         chki($sformatf("gap lat%0d", i), outc[i], be[5 + 2 * i]);
         if (i < ref_q.size()) chk($sformatf("gap vs b2b%0d", i), outq[i], ref_q[i]);
      end

      clrq(); start(1, 4);
      chki("w1 cfg_err", int'(cfg_err), 1);
      chki("w1 busy", int'(busy), 0);
      for (int j = 0; j < 4; j++) send(pix(3, 0, j), e);
      idle(3);
      chki("w1 no output", outq.size(), 0);
      start(417, 2);
      chki("w417 cfg_err", int'(cfg_err), 1);
      start(4, 1);
      chki("h1 cfg_err", int'(cfg_err), 1);
      start(2, 2);
      chki("w2h2 cfg_err", int'(cfg_err), 0);
      chki("w2h2 busy", int'(busy), 1);
      frame(3, 2, 2, 1'b0);
      chki("w2h2 count", outq.size(), 1);
      if (outq.size() > 0) chk("w2h2 data", outq[0], win(3, 0, 0));
      start(416, 2);
      chki("w416 busy", int'(busy), 1);
      chki("w416 cfg_err", int'(cfg_err), 0);

      clrq(); start(4, 2);
      for (int j = 0; j < 3; j++) send(pix(4, 0, j), e);
      start(4, 2, 1'b1, pix(4, 0, 0));
      frame(3, 4, 2, 1'b0);
      chki("restart count", outq.size(), 2);
      for (int i = 0; i < 2 && i < outq.size(); i++) chk($sformatf("restart win%0d", i), outq[i], win(3, 0, i));

      clrq(); start(4, 2);
      for (int j = 0; j < 5; j++) send(pix(4, j / 4, j % 4), e);
      @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
      #1;
      chki("rst out_valid", int'(out_valid), 0);
      chk("rst out_data", out_data, '0);
      chki("rst busy", int'(busy), 0);
      chki("rst frame_done", int'(frame_done), 0);
      @(negedge clk); rst_n = 1'b1;
      for (int j = 1; j < 4; j++) send(pix(4, 1, j), e);
      idle(3);
      chki("rst no stale", outq.size(), 0);
      start(2, 2);
      frame(2, 2, 2, 1'b0);
      chki("rst recover count", outq.size(), 1);
      if (outq.size() > 0) chk("rst recover data", outq[0], win(2, 0, 0));

`ifdef CNN_MAXPOOL_BYPASS_EN
      clrq(); pool_en = 1'b0; start(4, 2); pool_en = 1'b1;
      frame(2, 4, 2, 1'b0);
      chki("bypass count", outq.size(), 8);
      for (int i = 0; i < 8 && i < outq.size(); i++) begin
         chk($sformatf("bypass data%0d", i), outq[i], pix(2, i / 4, i % 4));
         chki($sformatf("bypass lat%0d", i), outc[i], be[i]);
      end
      chki("bypass done", donec.size() > 0 ? donec[0] : -1, be[7]);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
